branch_resolver: RTL and testbench
==================================

# branch_resolver

Multicycle branch-resolution sequencer for the MIPS datapath. It takes a branch request from the main control unit, latches the two register operands, and compares them. It then drives the condition-select code and the comparison flags consumed by the PC-write-condition multiplexer, together with a one-cycle PC-write-condition strobe. It sits between the register-file output latches (A/B) and the PC write-enable logic.

## Interface

Parameters:
- WIDTH, 32, operand width in bits.
- CNT_WIDTH, 16, width of the taken-branch statistics counter.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-high; clears all state immediately.
- start, input, 1, one-cycle branch request from main control.
- br_type, input, 2, branch kind: 00 bne, 01 beq, 10 bgt, 11 ble. Sampled with start.
- op_a, input, WIDTH, register A value. Sampled with start.
- op_b, input, WIDTH, register B value. Sampled with start.
- pc_write_cond_mux, output, 2, condition select; equals the latched br_type.
- not_zero_n, output, 1, active-low inequality flag; 0 when A≠B. The downstream mux inverts it.
- zero, output, 1, 1 when A−B equals 0.
- maior, output, 1, 1 when A>B, signed.
- menor, output, 1, 1 when A<B, signed.
- igual, output, 1, 1 when A==B.
- pc_write_cond, output, 1, one-cycle strobe; the flags and select are valid in that cycle.
- taken, output, 1, internally resolved outcome; valid only with pc_write_cond.
- busy, output, 1, high whenever state ≠ IDLE.
- overrun, output, 1, sticky; set when start arrives while busy.
- taken_count, output, CNT_WIDTH, saturating count of taken branches.

## Operation

FSM states: IDLE, COMPARE, RESOLVE.
- **IDLE**: on start=1, latch br_type, op_a and op_b, then go to COMPARE. Otherwise stay in IDLE.
- **COMPARE**: compute A−B at WIDTH+1 bits on the latched operands, register all flags, then go to RESOLVE.
- **RESOLVE**: assert pc_write_cond and taken for one cycle, update taken_count, then go to IDLE.

Flag and width rules:
- Signed compare uses the sign of the (WIDTH+1)-bit difference, so there is no overflow error at extreme values.
- zero and igual are always equal. not_zero_n equals zero.
- Exactly one of maior, menor, igual is 1 once the flags are registered.

Taken rules:
- bne: taken = ~igual.
- beq: taken = zero.
- bgt: taken = maior.
- ble: taken = menor | igual.

taken_count increments on a taken RESOLVE and holds at all-ones.

Busy and overrun:
- start while busy is ignored: no relatch, state unaffected.
- overrun is set in that case and cleared only by reset.

Hold rules:
- Flags and pc_write_cond_mux hold their last values in IDLE.
- pc_write_cond and taken are 0 outside RESOLVE.

## Timing

- start sampled at edge N. COMPARE occupies cycle N+1. pc_write_cond is high in cycle N+2.
- Request-to-strobe latency is fixed at 2 cycles. Throughput is one branch per 3 cycles.
- A new start is accepted in the cycle immediately after RESOLVE, when busy=0.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset values: state IDLE, and all of the following 0: pc_write_cond_mux, not_zero_n, zero, maior, menor, igual, pc_write_cond, taken, busy, overrun, taken_count.
- Reset asserted mid-operation aborts the request at once. No strobe is issued after reset deasserts.
- start in the first edge after reset deassertion is accepted normally.

## Structure

- Package branch_pkg holds:
  - br_type encodings BR_BNE=2'b00, BR_BEQ=2'b01, BR_BGT=2'b10, BR_BLE=2'b11.
  - FSM state encodings.
- Sub-module branch_comparator: purely combinational (WIDTH+1)-bit subtract and flag derivation on the latched operands. It is instantiated once.
- Top level holds the operand latches, FSM, flag registers, taken logic, counter and overrun.

## Test plan

- **beq equal:** start, br_type=01, A=B=5.
  - Expected at N+2: pc_write_cond=1, zero=1, igual=1, not_zero_n=1, taken=1, taken_count=1.
- **bne equal:** br_type=00, A=B=7.
  - Expected: taken=0, not_zero_n=1, taken_count unchanged.
- **bgt signed extremes:** br_type=10, A=0x7FFFFFFF, B=0x80000000.
  - Expected: maior=1, menor=0, taken=1, with no overflow misresolve.
- **ble equality and less:** br_type=11.
  - A=B=0xFFFFFFFF: expect taken=1.
  - A=−1, B=−2: expect taken=0, maior=1.
- **start while busy:** second start at N+1 with different operands.
  - Expected: ignored, first result strobed at N+2, overrun=1 sticky.
  - Also: a start at N+3 is accepted.
- **Reset and saturation:**
  - Assert reset during COMPARE: all outputs go to 0 immediately, and no strobe appears afterwards.
  - With CNT_WIDTH=2 and 5 taken branches: taken_count holds at 3.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared encodings for the branch-resolution sequencer: branch kinds as
// decoded by main control, and the sequencer's FSM states.
package branch_pkg;

    localparam logic [1:0] BR_BNE = 2'b00;
    localparam logic [1:0] BR_BEQ = 2'b01;
    localparam logic [1:0] BR_BGT = 2'b10;
    localparam logic [1:0] BR_BLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COMPARE = 2'b01,
        ST_RESOLVE = 2'b10
    } state_t;

endpackage

// File: rtl/branch_comparator.sv
// Combinational operand comparator. Both operands are sign-extended by one
// bit before subtracting, so the sign of the (WIDTH+1)-bit difference is
// always the true signed ordering, even for the most positive minus the
// most negative value.
module branch_comparator #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    logic [WIDTH:0] diff;

    // Wide difference plus flag derivation; exactly one flag is ever high.
    always_comb begin
        diff = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        eq   = (diff == '0);
        lt   = diff[WIDTH];
        gt   = ~(diff == '0) & ~diff[WIDTH];
    end

endmodule

// File: rtl/branch_resolver.sv
// Multicycle branch-resolution sequencer. A request is latched in IDLE,
// compared in COMPARE, and strobed to the PC write-enable logic for one
// cycle in RESOLVE. All outputs come from registers.
module branch_resolver #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           br_type,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic [1:0]           pc_write_cond_mux,
    output logic                 not_zero_n,
    output logic                 zero,
    output logic                 maior,
    output logic                 menor,
    output logic                 igual,
    output logic                 pc_write_cond,
    output logic                 taken,
    output logic                 busy,
    output logic                 overrun,
    output logic [CNT_WIDTH-1:0] taken_count
);

    import branch_pkg::*;

    state_t           state;
    state_t           state_next;
    logic [1:0]       type_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             cmp_eq;
    logic             cmp_gt;
    logic             cmp_lt;
    logic             taken_c;

    branch_comparator #(.WIDTH(WIDTH)) u_cmp (
        .a  (a_q),
        .b  (b_q),
        .eq (cmp_eq),
        .gt (cmp_gt),
        .lt (cmp_lt)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state logic: one fixed pass IDLE -> COMPARE -> RESOLVE -> IDLE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (start) state_next = ST_COMPARE;
            ST_COMPARE: state_next = ST_RESOLVE;
            ST_RESOLVE: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Branch outcome from the latched kind and the comparator flags.
    always_comb begin
        taken_c = 1'b0;
        case (type_q)
            BR_BNE:  taken_c = ~cmp_eq;
            BR_BEQ:  taken_c = cmp_eq;
            BR_BGT:  taken_c = cmp_gt;
            BR_BLE:  taken_c = cmp_lt | cmp_eq;
            default: taken_c = 1'b0;
        endcase
    end

    // Operand latches, flag registers, strobe, counter and sticky overrun.
    // Flags are captured on the COMPARE->RESOLVE edge so they are valid with
    // the strobe and then simply hold through IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            type_q            <= '0;
            a_q               <= '0;
            b_q               <= '0;
            pc_write_cond_mux <= '0;
            not_zero_n        <= 1'b0;
            zero              <= 1'b0;
            maior             <= 1'b0;
            menor             <= 1'b0;
            igual             <= 1'b0;
            pc_write_cond     <= 1'b0;
            taken             <= 1'b0;
            overrun           <= 1'b0;
            taken_count       <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                type_q <= br_type;
                a_q    <= op_a;
                b_q    <= op_b;
            end
            if (state != ST_IDLE && start) begin
                overrun <= 1'b1;
            end
            if (state == ST_COMPARE) begin
                pc_write_cond_mux <= type_q;
                not_zero_n        <= cmp_eq;
                zero              <= cmp_eq;
                igual             <= cmp_eq;
                maior             <= cmp_gt;
                menor             <= cmp_lt;
                pc_write_cond     <= 1'b1;
                taken             <= taken_c;
                if (taken_c && taken_count != {CNT_WIDTH{1'b1}}) begin
                    taken_count <= taken_count + 1'b1;
                end
            end else begin
                pc_write_cond <= 1'b0;
                taken         <= 1'b0;
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver. A second instance with a 2-bit
// counter shares the same stimulus to exercise counter saturation.
module tb_branch_resolver;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  br_type;
    logic [31:0] op_a;
    logic [31:0] op_b;

    logic [1:0]  pc_write_cond_mux;
    logic        not_zero_n, zero, maior, menor, igual;
    logic        pc_write_cond, taken, busy, overrun;
    logic [15:0] taken_count;

    logic [1:0]  s_mux;
    logic        s_nzn, s_zero, s_maior, s_menor, s_igual;
    logic        s_pcw, s_taken, s_busy, s_overrun;
    logic [1:0]  s_count;

    int   tests = 0;
    int   failures = 0;
    int   exp_count = 0;
    int   exp_sat = 0;
    logic exp_overrun = 1'b0;

    branch_resolver #(.WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .br_type(br_type),
        .op_a(op_a), .op_b(op_b),
        .pc_write_cond_mux(pc_write_cond_mux), .not_zero_n(not_zero_n),
        .zero(zero), .maior(maior), .menor(menor), .igual(igual),
        .pc_write_cond(pc_write_cond), .taken(taken), .busy(busy),
        .overrun(overrun), .taken_count(taken_count)
    );

    branch_resolver #(.WIDTH(32), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .reset(reset), .start(start), .br_type(br_type),
        .op_a(op_a), .op_b(op_b),
        .pc_write_cond_mux(s_mux), .not_zero_n(s_nzn),
        .zero(s_zero), .maior(s_maior), .menor(s_menor), .igual(s_igual),
        .pc_write_cond(s_pcw), .taken(s_taken), .busy(s_busy),
        .overrun(s_overrun), .taken_count(s_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference outcome straight from the branch rules, using signed integers.
    function automatic logic model_taken(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
        int sa = $signed(a);
        int sb = $signed(b);
        case (t)
            2'b00:   return sa != sb;
            2'b01:   return sa == sb;
            2'b10:   return sa > sb;
            default: return sa <= sb;
        endcase
    endfunction

    // Caller is at a negedge; start is sampled at the next rising edge.
    task automatic applyStimulus(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
        br_type = t;
        op_a    = a;
        op_b    = b;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic checkStrobe(input string tag, input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
        logic tk;
        int   sa;
        int   sb;
        tk = model_taken(t, a, b);
        sa = $signed(a);
        sb = $signed(b);
        if (tk) begin
            exp_count = (exp_count < 65535) ? exp_count + 1 : exp_count;
            exp_sat   = (exp_sat < 3) ? exp_sat + 1 : exp_sat;
        end
        checkOutput({tag, "/pcw"},     32'(pc_write_cond), 32'd1);
        checkOutput({tag, "/mux"},     32'(pc_write_cond_mux), 32'(t));
        checkOutput({tag, "/zero"},    32'(zero), 32'(sa == sb));
        checkOutput({tag, "/igual"},   32'(igual), 32'(sa == sb));
        checkOutput({tag, "/nzn"},     32'(not_zero_n), 32'(sa == sb));
        checkOutput({tag, "/maior"},   32'(maior), 32'(sa > sb));
        checkOutput({tag, "/menor"},   32'(menor), 32'(sa < sb));
        checkOutput({tag, "/taken"},   32'(taken), 32'(tk));
        checkOutput({tag, "/busy"},    32'(busy), 32'd1);
        checkOutput({tag, "/count"},   32'(taken_count), 32'(exp_count));
        checkOutput({tag, "/satcnt"},  32'(s_count), 32'(exp_sat));
        checkOutput({tag, "/overrun"}, 32'(overrun), 32'(exp_overrun));
    endtask

    task automatic checkIdle(input string tag, input logic exp_eq);
        checkOutput({tag, "/idle_pcw"},   32'(pc_write_cond), 32'd0);
        checkOutput({tag, "/idle_taken"}, 32'(taken), 32'd0);
        checkOutput({tag, "/idle_busy"},  32'(busy), 32'd0);
        checkOutput({tag, "/idle_zero"},  32'(zero), 32'(exp_eq));
    endtask

    // Full request: stimulus, bounded wait for the strobe, result and idle checks.
    task automatic runBranch(input string tag, input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
        int cycles;
        applyStimulus(t, a, b);
        cycles = 0;
        while (pc_write_cond !== 1'b1 && cycles < 6) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, "/latency"}, 32'(cycles), 32'd1);
        checkStrobe(tag, t, a, b);
        @(negedge clk);
        checkIdle(tag, a == b);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "/mux"},     32'(pc_write_cond_mux), 32'd0);
        checkOutput({tag, "/flags"},   32'({not_zero_n, zero, maior, menor, igual}), 32'd0);
        checkOutput({tag, "/pcw"},     32'(pc_write_cond), 32'd0);
        checkOutput({tag, "/taken"},   32'(taken), 32'd0);
        checkOutput({tag, "/busy"},    32'(busy), 32'd0);
        checkOutput({tag, "/overrun"}, 32'(overrun), 32'd0);
        checkOutput({tag, "/count"},   32'(taken_count), 32'd0);
        checkOutput({tag, "/satcnt"},  32'(s_count), 32'd0);
        checkOutput({tag, "/satbusy"}, 32'(s_busy), 32'd0);
    endtask

    initial begin
        logic [1:0]  rt;
        logic [31:0] ra;
        logic [31:0] rb;

        reset   = 1'b1;
        start   = 1'b0;
        br_type = 2'b00;
        op_a    = '0;
        op_b    = '0;
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        reset = 1'b0;

        // Directed cases, issued back to back.
        runBranch("beq_eq",   2'b01, 32'd5, 32'd5);
        runBranch("bne_eq",   2'b00, 32'd7, 32'd7);
        runBranch("bgt_ext",  2'b10, 32'h7FFF_FFFF, 32'h8000_0000);
        runBranch("ble_eq",   2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        runBranch("ble_gt",   2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        runBranch("bgt_ext2", 2'b10, 32'h8000_0000, 32'h7FFF_FFFF);
        runBranch("bne_ne",   2'b00, 32'd1, 32'd2);

        // Second start while in COMPARE must be ignored but flag overrun.
        applyStimulus(2'b01, 32'd9, 32'd9);
        br_type = 2'b00;
        op_a    = 32'd1;
        op_b    = 32'd2;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        exp_overrun = 1'b1;
        checkStrobe("busy_start", 2'b01, 32'd9, 32'd9);
        @(negedge clk);
        checkIdle("busy_start", 1'b1);
        runBranch("after_busy", 2'b10, 32'd5, 32'd3);

        // Randomized requests with a bias toward equal operands and extremes.
        for (int i = 0; i < 24; i++) begin
            rt = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       ra = 32'h8000_0000;
                1:       ra = 32'h7FFF_FFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ 32'h8000_0000;
                default: rb = $urandom;
            endcase
            runBranch($sformatf("rand%0d", i), rt, ra, rb);
        end

        // Reset during COMPARE clears everything at once and kills the strobe.
        applyStimulus(2'b01, 32'd4, 32'd4);
        #1 reset = 1'b1;
        #1;
        exp_count   = 0;
        exp_sat     = 0;
        exp_overrun = 1'b0;
        checkAllZero("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("no_strobe%0d", i), 32'(pc_write_cond), 32'd0);
        end

        // Enough taken branches to pin the 2-bit counter at 3.
        for (int i = 0; i < 5; i++) begin
            runBranch($sformatf("sat%0d", i), 2'b01, 32'(i), 32'(i));
        end
        checkOutput("sat_hold", 32'(s_count), 32'd3);
        checkOutput("wide_count", 32'(taken_count), 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
